// File: rtl/entropy_src_ht_window_ctrl.sv
// Window sequencer and statistics/alert tracker for the adaptive-proportion health test.
// Optional build macro: ENTROPY_SRC_HT_WINDOW_STARTUP_EN (first two windows after start/clear are strict).
module entropy_src_ht_window_ctrl #(
    parameter int unsigned RegWidth     = 16,
    parameter int unsigned WinWidth     = 16,
    parameter int unsigned FailCntWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic [WinWidth-1:0]     window_size_i,
    input  logic [FailCntWidth-1:0] alert_thresh_i,
    input  logic                    entropy_bit_vld_i,
    input  logic [RegWidth-1:0]     test_cnt_hi_i,
    input  logic [RegWidth-1:0]     test_cnt_lo_i,
    input  logic                    fail_hi_pulse_i,
    input  logic                    fail_lo_pulse_i,
    output logic                    active_o,
    output logic                    ht_clear_o,
    output logic                    window_wrap_pulse_o,
    output logic [WinWidth-1:0]     window_cnt_o,
    output logic [RegWidth-1:0]     hi_watermark_o,
    output logic [RegWidth-1:0]     lo_watermark_o,
    output logic [RegWidth-1:0]     total_fail_cnt_o,
    output logic [FailCntWidth-1:0] consec_fail_cnt_o,
    output logic                    alert_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALERT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WinWidth-1:0]     win_size_q;
    logic [WinWidth-1:0]     win_cnt_q;
    logic [WinWidth-1:0]     win_last;
    logic                    wrap_q;
    logic [RegWidth-1:0]     hi_wm_q, lo_wm_q, total_q, total_nxt;
    logic [FailCntWidth-1:0] consec_q, consec_nxt;
    logic                    win_fail, wrap_take, alert_hit, ht_clear;
    logic                    sample_take, in_startup;

    assign win_last    = win_size_q - WinWidth'(1);
    // The wrap cycle drops vld, matching the datapath where its clear wins.
    assign sample_take = (state_q == ST_RUN) && !wrap_q && entropy_bit_vld_i;

    always_comb begin
        state_d    = state_q;
        ht_clear   = 1'b0;
        win_fail   = fail_hi_pulse_i | fail_lo_pulse_i;
        wrap_take  = wrap_q && (state_q == ST_RUN) && enable_i && !clear_i;
        consec_nxt = '0;
        total_nxt  = total_q;
        if (win_fail) begin
            consec_nxt = (consec_q == '1) ? consec_q : consec_q + FailCntWidth'(1);
            if (total_q != '1) begin
                total_nxt = total_q + RegWidth'(1);
            end
        end
        alert_hit = (win_fail && in_startup) ||
                    ((alert_thresh_i != '0) && (consec_nxt >= alert_thresh_i));
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d  = ST_RUN;
                    ht_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_d  = ST_IDLE;
                    ht_clear = 1'b1;
                end else if (clear_i) begin
                    ht_clear = 1'b1;
                end else if (wrap_take && alert_hit) begin
                    state_d = ST_ALERT;
                end
            end
            ST_ALERT: begin
                if (!enable_i) begin
                    state_d  = ST_IDLE;
                    ht_clear = 1'b1;
                end else if (clear_i) begin
                    state_d  = ST_RUN;
                    ht_clear = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            win_size_q <= WinWidth'(2);
            win_cnt_q  <= '0;
            wrap_q     <= 1'b0;
            hi_wm_q    <= '0;
            lo_wm_q    <= '1;
            total_q    <= '0;
            consec_q   <= '0;
        end else begin
            state_q <= state_d;
            wrap_q  <= 1'b0;
            if (state_q == ST_IDLE && enable_i) begin
                win_size_q <= (window_size_i < WinWidth'(2)) ? WinWidth'(2) : window_size_i;
            end
            if (ht_clear) begin
                win_cnt_q <= '0;
            end else if (sample_take) begin
                if (win_cnt_q == win_last) begin
                    win_cnt_q <= '0;
                    wrap_q    <= 1'b1;
                end else begin
                    win_cnt_q <= win_cnt_q + WinWidth'(1);
                end
            end
            if (clear_i) begin
                hi_wm_q  <= '0;
                lo_wm_q  <= '1;
                total_q  <= '0;
                consec_q <= '0;
            end else if (wrap_take) begin
                if (!in_startup) begin
                    if (test_cnt_hi_i > hi_wm_q) hi_wm_q <= test_cnt_hi_i;
                    if (test_cnt_lo_i < lo_wm_q) lo_wm_q <= test_cnt_lo_i;
                end
                total_q  <= total_nxt;
                consec_q <= consec_nxt;
            end
        end
    end

`ifdef ENTROPY_SRC_HT_WINDOW_STARTUP_EN
    logic [1:0] startup_win_q;

    assign in_startup = (startup_win_q != 2'd2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            startup_win_q <= '0;
        end else if (clear_i || (state_q == ST_IDLE && enable_i)) begin
            startup_win_q <= '0;
        end else if (wrap_take && in_startup) begin
            startup_win_q <= startup_win_q + 2'd1;
        end
    end
`else
    assign in_startup = 1'b0;
`endif

    assign active_o            = (state_q == ST_RUN);
    assign alert_o             = (state_q == ST_ALERT);
    assign ht_clear_o          = ht_clear & ~rst_i;
    assign window_wrap_pulse_o = wrap_q;
    assign window_cnt_o        = win_cnt_q;
    assign hi_watermark_o      = hi_wm_q;
    assign lo_watermark_o      = lo_wm_q;
    assign total_fail_cnt_o    = total_q;
    assign consec_fail_cnt_o   = consec_q;

endmodule

// File: tb/tb_entropy_src_ht_window_ctrl.sv
// Self-checking bench for entropy_src_ht_window_ctrl: directed scenarios plus randomized
// stimulus against a behavioural model of the window/statistics rules.
module tb_entropy_src_ht_window_ctrl;

`ifdef ENTROPY_SRC_HT_WINDOW_STARTUP_EN
    localparam bit STARTUP = 1'b1;
`else
    localparam bit STARTUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, enable_i = 1'b0, clear_i = 1'b0, entropy_bit_vld_i = 1'b0;
    logic [15:0] window_size_i = '0, test_cnt_hi_i = '0, test_cnt_lo_i = '0;
    logic [3:0]  alert_thresh_i = '0;
    logic        fail_hi_pulse_i = 1'b0, fail_lo_pulse_i = 1'b0;
    logic        active_o, ht_clear_o, window_wrap_pulse_o, alert_o;
    logic [15:0] window_cnt_o, hi_watermark_o, lo_watermark_o, total_fail_cnt_o;
    logic [3:0]  consec_fail_cnt_o;

    always #5 clk = ~clk;

    entropy_src_ht_window_ctrl #(.RegWidth(16), .WinWidth(16), .FailCntWidth(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .window_size_i(window_size_i), .alert_thresh_i(alert_thresh_i),
        .entropy_bit_vld_i(entropy_bit_vld_i), .test_cnt_hi_i(test_cnt_hi_i),
        .test_cnt_lo_i(test_cnt_lo_i), .fail_hi_pulse_i(fail_hi_pulse_i),
        .fail_lo_pulse_i(fail_lo_pulse_i), .active_o(active_o), .ht_clear_o(ht_clear_o),
        .window_wrap_pulse_o(window_wrap_pulse_o), .window_cnt_o(window_cnt_o),
        .hi_watermark_o(hi_watermark_o), .lo_watermark_o(lo_watermark_o),
        .total_fail_cnt_o(total_fail_cnt_o), .consec_fail_cnt_o(consec_fail_cnt_o),
        .alert_o(alert_o)
    );

    int errors = 0;
    int checks = 0;

    // Model: mode 0=idle 1=running 2=alerted; samples counted per window; windows closed since restart.
    int m_mode = 0, m_w = 2, m_cnt = 0, m_hi = 0, m_lo = 65535, m_total = 0, m_consec = 0, m_windows = 0;
    bit m_wrap = 1'b0;
    bit e_active, e_alert, e_wrap, e_clr;
    int e_cnt, e_hi, e_lo, e_total, e_consec;

    // Apply one cycle of inputs at the falling edge, record the outputs expected during that
    // cycle, advance the model past the next rising edge, then wait until just before it.
    task automatic drive(input bit rst, input bit en, input bit clr, input int ws, input int th,
                         input bit vld, input int hi, input int lo, input bit fh, input bit fl);
        bit closing, nwrap, f, startup;
        int next_mode;
        @(negedge clk);
        rst_i = rst; enable_i = en; clear_i = clr; window_size_i = 16'(ws);
        alert_thresh_i = 4'(th); entropy_bit_vld_i = vld; test_cnt_hi_i = 16'(hi);
        test_cnt_lo_i = 16'(lo); fail_hi_pulse_i = fh; fail_lo_pulse_i = fl;
        e_active = (m_mode == 1); e_alert = (m_mode == 2); e_wrap = m_wrap; e_cnt = m_cnt;
        e_hi = m_hi; e_lo = m_lo; e_total = m_total; e_consec = m_consec;
        e_clr = !rst && ((m_mode == 0 && en) || (m_mode != 0 && (clr || !en)));
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_wrap = 0; m_hi = 0; m_lo = 65535;
            m_total = 0; m_consec = 0; m_windows = 0;
        end else begin
            closing = m_wrap && m_mode == 1 && en && !clr;
            next_mode = m_mode;
            if (m_mode == 0 && en) begin
                next_mode = 1; m_w = (ws < 2) ? 2 : ws; m_windows = 0;
            end else if (m_mode != 0 && !en) begin
                next_mode = 0;
            end else if (m_mode != 0 && clr) begin
                next_mode = 1;
            end
            nwrap = 0;
            if (e_clr) m_cnt = 0;
            else if (m_mode == 1 && !m_wrap && vld) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == m_w) begin m_cnt = 0; nwrap = 1; end
            end
            if (clr) begin
                m_hi = 0; m_lo = 65535; m_total = 0; m_consec = 0; m_windows = 0;
            end else if (closing) begin
                f = fh | fl;
                startup = STARTUP && (m_windows < 2);
                if (!startup) begin
                    if (hi > m_hi) m_hi = hi;
                    if (lo < m_lo) m_lo = lo;
                end
                if (f) begin
                    m_total = (m_total < 65535) ? m_total + 1 : 65535;
                    m_consec = (m_consec < 15) ? m_consec + 1 : 15;
                end else m_consec = 0;
                if ((f && startup) || (th != 0 && m_consec >= th)) next_mode = 2;
                m_windows = m_windows + 1;
            end
            m_wrap = nwrap; m_mode = next_mode;
        end
        #4;
    endtask

    task automatic reset_dut();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 5, 3, 1, 9, 9, 1, 1);
        drive(1, 1, 1, 5, 3, 1, 9, 9, 1, 1);
        checks++;
        if ({active_o, alert_o, ht_clear_o, window_wrap_pulse_o, window_cnt_o, hi_watermark_o,
             lo_watermark_o, total_fail_cnt_o, consec_fail_cnt_o} !==
            {4'b0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'h0}) begin
            errors++;
            $display("FAIL reset_state act=%b alert=%b clr=%b wrap=%b cnt=%0d hi=%0d lo=%h tot=%0d con=%0d, required all 0 and lo=ffff",
                     active_o, alert_o, ht_clear_o, window_wrap_pulse_o, window_cnt_o,
                     hi_watermark_o, lo_watermark_o, total_fail_cnt_o, consec_fail_cnt_o);
        end
        drive(0, 0, 0, 5, 3, 1, 0, 0, 0, 0);
        checks++;
        if (active_o !== 1'b0 || ht_clear_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold act=%b clr=%b, required 0 0", active_o, ht_clear_o);
        end
    endtask

    task automatic test_window_wrap();
        int p, exp_cnt;
        reset_dut();
        for (int c = 0; c <= 16; c++) begin
            drive(0, 1, 0, 4, 0, 1, 0, 0, 0, 0);
            if (c == 0) begin
                checks++;
                if (ht_clear_o !== 1'b1) begin
                    errors++; $display("FAIL start_clear ht_clear=%b, required 1", ht_clear_o);
                end
            end
            p = (c - 1) % 5;
            exp_cnt = (c == 0 || p == 4) ? 0 : p;
            checks++;
            if (window_wrap_pulse_o !== ((c == 5 || c == 10 || c == 15) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL w4_wrap cycle=%0d got %b", c, window_wrap_pulse_o);
            end
            checks++;
            if (window_cnt_o !== 16'(exp_cnt)) begin
                errors++; $display("FAIL w4_cnt cycle=%0d got %0d required %0d", c, window_cnt_o, exp_cnt);
            end
        end
    endtask

    task automatic test_min_window();
        int p, exp_cnt;
        reset_dut();
        for (int c = 0; c <= 6; c++) begin
            drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
            p = (c - 1) % 3;
            exp_cnt = (c == 0 || p == 2) ? 0 : p;
            checks++;
            if (window_wrap_pulse_o !== ((c == 3 || c == 6) ? 1'b1 : 1'b0) ||
                window_cnt_o !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL w0_window cycle=%0d wrap=%b cnt=%0d required cnt %0d",
                         c, window_wrap_pulse_o, window_cnt_o, exp_cnt);
            end
        end
    endtask

    task automatic test_alert_thresh();
        reset_dut();
        // Two passing windows first so the startup rule cannot affect the outcome.
        for (int c = 0; c <= 16; c++) begin
            drive(0, 1, 0, 2, 3, 1, 0, 0, (c >= 7), 0);
            if (c == 10 || c == 13) begin
                checks++;
                if (consec_fail_cnt_o !== 4'((c - 7) / 3)) begin
                    errors++; $display("FAIL consec_ramp cycle=%0d got %0d", c, consec_fail_cnt_o);
                end
            end
            if (c == 15) begin
                checks++;
                if (alert_o !== 1'b0 || active_o !== 1'b1) begin
                    errors++; $display("FAIL early_alert alert=%b active=%b, required 0 1", alert_o, active_o);
                end
            end
        end
        checks++;
        if (consec_fail_cnt_o !== 4'd3 || alert_o !== 1'b1 || active_o !== 1'b0 ||
            total_fail_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL alert_entry con=%0d alert=%b active=%b tot=%0d, required 3 1 0 3",
                     consec_fail_cnt_o, alert_o, active_o, total_fail_cnt_o);
        end
        drive(0, 1, 1, 2, 3, 1, 0, 0, 1, 0);
        checks++;
        if (ht_clear_o !== 1'b1) begin
            errors++; $display("FAIL alert_clear_pulse ht_clear=%b, required 1", ht_clear_o);
        end
        drive(0, 1, 0, 2, 3, 0, 0, 0, 0, 0);
        checks++;
        if (alert_o !== 1'b0 || active_o !== 1'b1 || consec_fail_cnt_o !== 4'd0 ||
            total_fail_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL alert_cleared alert=%b active=%b con=%0d tot=%0d, required 0 1 0 0",
                     alert_o, active_o, consec_fail_cnt_o, total_fail_cnt_o);
        end
    endtask

    task automatic test_watermarks();
        int his[4] = '{5, 6, 10, 7};
        int los[4] = '{8, 9, 3, 5};
        int idx;
        reset_dut();
        for (int c = 0; c <= 12; c++) begin
            idx = (c == 0) ? 0 : (c - 1) / 3;
            if (idx > 3) idx = 3;
            drive(0, 1, 0, 2, 0, 1, his[idx], los[idx], 0, 0);
        end
        drive(0, 1, 1, 2, 0, 1, 0, 0, 0, 0);
        checks++;
        if (hi_watermark_o !== 16'd10 || lo_watermark_o !== 16'd3) begin
            errors++; $display("FAIL watermarks hi=%0d lo=%0d, required 10 3", hi_watermark_o, lo_watermark_o);
        end
        checks++;
        if (ht_clear_o !== 1'b1) begin
            errors++; $display("FAIL clear_pulse ht_clear=%b, required 1", ht_clear_o);
        end
        drive(0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        checks++;
        if (hi_watermark_o !== 16'd0 || lo_watermark_o !== 16'hFFFF || window_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL wm_cleared hi=%0d lo=%h cnt=%0d, required 0 ffff 0",
                     hi_watermark_o, lo_watermark_o, window_cnt_o);
        end
    endtask

    task automatic test_fail_pass_fail_enable_drop();
        bit pat[5] = '{0, 0, 1, 0, 1};
        int idx;
        reset_dut();
        for (int c = 0; c <= 16; c++) begin
            idx = (c == 0) ? 0 : (c - 1) / 3;
            if (idx > 4) idx = 4;
            drive(0, 1, 0, 2, 2, 1, 0, 0, 0, pat[idx]);
            if (c == 10 || c == 13 || c == 16) begin
                checks++;
                if (consec_fail_cnt_o !== ((c == 13) ? 4'd0 : 4'd1) || alert_o !== 1'b0) begin
                    errors++;
                    $display("FAIL fpf cycle=%0d con=%0d alert=%b", c, consec_fail_cnt_o, alert_o);
                end
            end
        end
        drive(0, 0, 0, 2, 2, 1, 0, 0, 0, 0);
        checks++;
        if (ht_clear_o !== 1'b1 || window_cnt_o !== 16'd1) begin
            errors++; $display("FAIL drop_pulse ht_clear=%b cnt=%0d, required 1 1", ht_clear_o, window_cnt_o);
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 2, 2, 1, 0, 0, 0, 0);
            checks++;
            if (window_wrap_pulse_o !== 1'b0 || active_o !== 1'b0 || window_cnt_o !== 16'd0 ||
                total_fail_cnt_o !== 16'd2) begin
                errors++;
                $display("FAIL drop_idle step=%0d wrap=%b active=%b cnt=%0d tot=%0d, required 0 0 0 2",
                         c, window_wrap_pulse_o, active_o, window_cnt_o, total_fail_cnt_o);
            end
        end
    endtask

    task automatic test_startup();
        reset_dut();
        for (int c = 0; c <= 4; c++) drive(0, 1, 0, 2, 0, 1, 0, 0, 1, 0);
        checks++;
        if (alert_o !== STARTUP || consec_fail_cnt_o !== 4'd1) begin
            errors++;
            $display("FAIL startup_alert alert=%b con=%0d, required %b 1", alert_o, consec_fail_cnt_o, STARTUP);
        end
    endtask

    task automatic test_random();
        bit rst, en, clr, vld, fh, fl;
        int ws, th;
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin
                rst = ($urandom_range(199) == 0); en = ($urandom_range(99) >= 3);
                clr = ($urandom_range(99) < 2); th = $urandom_range(5);
                fh = ($urandom_range(99) < 20); fl = ($urandom_range(99) < 15);
            end else begin
                rst = 0; en = ($urandom_range(999) >= 2); clr = ($urandom_range(999) < 2);
                th = 0; fh = ($urandom_range(99) < 95); fl = 0;
            end
            ws = $urandom_range(5); vld = ($urandom_range(99) < 70);
            drive(rst, en, clr, ws, th, vld, $urandom_range(65535), $urandom_range(65535), fh, fl);
            checks++;
            if ({active_o, alert_o, ht_clear_o, window_wrap_pulse_o} !== {e_active, e_alert, e_clr, e_wrap} ||
                window_cnt_o !== 16'(e_cnt) || hi_watermark_o !== 16'(e_hi) ||
                lo_watermark_o !== 16'(e_lo) || total_fail_cnt_o !== 16'(e_total) ||
                consec_fail_cnt_o !== 4'(e_consec)) begin
                errors++;
                $display("FAIL random i=%0d got act/alert/clr/wrap=%b%b%b%b cnt=%0d hi=%0d lo=%0d tot=%0d con=%0d required %b%b%b%b cnt=%0d hi=%0d lo=%0d tot=%0d con=%0d",
                         i, active_o, alert_o, ht_clear_o, window_wrap_pulse_o, window_cnt_o,
                         hi_watermark_o, lo_watermark_o, total_fail_cnt_o, consec_fail_cnt_o,
                         e_active, e_alert, e_clr, e_wrap, e_cnt, e_hi, e_lo, e_total, e_consec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window_wrap();
        test_min_window();
        test_alert_thresh();
        test_watermarks();
        test_fail_pass_fail_enable_drop();
        test_startup();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
